// File: rtl/router_alloc_pkg.sv
// Shared types and helpers for the router output-port allocator.
package router_alloc_pkg;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_e;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Next round-robin index; n need not be a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority arbiter: the first requester at or after
// ptr (wrapping) wins. Implemented as a minimum-distance search from ptr.
module rr_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W:0] best_d;
  logic [IDX_W:0] d;

  always_comb begin
    best_d = '1;
    d      = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) >= ptr) d = (IDX_W+1)'(i) - {1'b0, ptr};
      else                  d = (IDX_W+1)'(i + N) - {1'b0, ptr};
      if (req[i] && (d < best_d)) begin
        best_d = d;
        idx    = IDX_W'(i);
      end
    end
  end

  assign any = |req;
  assign gnt = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/output_port_allocator.sv
// Per-output-port wormhole switch allocator with downstream credit tracking.
// Optional build macro OUTPUT_ALLOC_TURN_MASK_EN adds the turn_disable mask.
module output_port_allocator
  import router_alloc_pkg::*;
#(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int CREDIT_W          = credit_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef OUTPUT_ALLOC_TURN_MASK_EN
  input  logic [NUM_INPUTS-1:0]         turn_disable,
`endif
  input  logic [NUM_INPUTS-1:0]         req,
  input  logic [NUM_INPUTS-1:0]         req_is_tail,
  input  logic                          credit_in,
  output logic [NUM_INPUTS-1:0]         grant,
  output logic                          send_out,
  output logic                          locked,
  output logic [$clog2(NUM_INPUTS)-1:0] owner,
  output logic [CREDIT_W-1:0]           credit_count,
  output logic                          credit_err
);

  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(FLIT_BUFFER_DEPTH);

  alloc_state_e            state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CREDIT_W-1:0]     credit_q;
  logic                    err_q;
  logic [NUM_INPUTS-1:0]   eligible;
  logic [NUM_INPUTS-1:0]   arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic [NUM_INPUTS-1:0]   grant_c;
  logic                    has_credit;

`ifdef OUTPUT_ALLOC_TURN_MASK_EN
  assign eligible = req & ~turn_disable;
`else
  assign eligible = req;
`endif

  assign has_credit = (credit_q != '0);

  rr_arbiter #(
    .N     (NUM_INPUTS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    grant_c = '0;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ALLOC_IDLE: begin
        if (has_credit && arb_any) begin
          grant_c = arb_gnt;
          owner_d = arb_idx;
          if (req_is_tail[arb_idx]) ptr_d = IDX_W'(rr_next(int'(arb_idx), NUM_INPUTS));
          else                      state_d = ALLOC_LOCKED;
        end
      end
      ALLOC_LOCKED: begin
        // Only the owner may send mid-packet; a missing req is just a bubble.
        if (has_credit && req[owner_q]) begin
          grant_c[owner_q] = 1'b1;
          if (req_is_tail[owner_q]) begin
            state_d = ALLOC_IDLE;
            ptr_d   = IDX_W'(rr_next(int'(owner_q), NUM_INPUTS));
          end
        end
      end
      default: state_d = ALLOC_IDLE;
    endcase
  end

  assign grant    = rst_n ? grant_c : '0;
  assign send_out = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ALLOC_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Simultaneous send and credit return cancel; overflow saturates and sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= CREDIT_MAX;
      err_q    <= 1'b0;
    end else if (credit_in && !send_out) begin
      if (credit_q == CREDIT_MAX) err_q <= 1'b1;
      else                        credit_q <= credit_q + CREDIT_W'(1);
    end else if (send_out && !credit_in) begin
      credit_q <= credit_q - CREDIT_W'(1);
    end
  end

  assign locked       = (state_q == ALLOC_LOCKED);
  assign owner        = owner_q;
  assign credit_count = credit_q;
  assign credit_err   = err_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Scoreboard bench for output_port_allocator: scripted scenarios plus random
// traffic, checked against a packet-level reference model.
module tb_output_port_allocator;

  localparam int NI = 5;
  localparam int D  = 2;
  localparam int CW = $clog2(D + 1);
  localparam int IW = $clog2(NI);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] req = '0;
  logic [NI-1:0] req_is_tail = '0;
  logic          credit_in = 1'b0;
  logic [NI-1:0] grant;
  logic          send_out;
  logic          locked;
  logic [IW-1:0] owner;
  logic [CW-1:0] credit_count;
  logic          credit_err;
`ifdef OUTPUT_ALLOC_TURN_MASK_EN
  logic [NI-1:0] turn_disable = '0;
`endif

  output_port_allocator #(
    .NUM_INPUTS        (NI),
    .FLIT_BUFFER_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef OUTPUT_ALLOC_TURN_MASK_EN
    .turn_disable (turn_disable),
`endif
    .req          (req),
    .req_is_tail  (req_is_tail),
    .credit_in    (credit_in),
    .grant        (grant),
    .send_out     (send_out),
    .locked       (locked),
    .owner        (owner),
    .credit_count (credit_count),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NI-1:0] grant;
    bit            locked;
    int            owner;
    int            credits;
    bit            err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: packet ownership, rotating priority start, credit pool.
  int            m_ptr, m_owner, m_credits;
  bit            m_locked, m_err;
  logic [NI-1:0] m_mask = '0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_credits = D; m_locked = 0; m_err = 0;
  endtask

  function automatic bit bit_of(input logic [NI-1:0] v, input int i);
    return ((v >> i) & NI'(1)) != '0;
  endfunction

  function automatic int model_pick(input logic [NI-1:0] r);
    int sel;
    sel = -1;
    if (m_credits > 0) begin
      if (!m_locked) begin
        for (int k = 0; k < NI; k++) begin
          int j;
          j = (m_ptr + k) % NI;
          if (sel < 0 && bit_of(r, j) && !bit_of(m_mask, j)) sel = j;
        end
      end else if (bit_of(r, m_owner)) begin
        sel = m_owner;
      end
    end
    return sel;
  endfunction

  task automatic step(input logic [NI-1:0] r, input logic [NI-1:0] t, input logic c);
    exp_t e;
    int   sel;
    @(posedge clk);
    #1;
    req = r; req_is_tail = t; credit_in = c;
    sel = model_pick(r);
    e.grant   = (sel >= 0) ? (NI'(1) << sel) : '0;
    e.locked  = m_locked;
    e.owner   = m_owner;
    e.credits = m_credits;
    e.err     = m_err;
    sb.push_back(e);
    if (sel >= 0) begin
      m_owner = sel;
      if (bit_of(t, sel)) begin
        m_locked = 0;
        m_ptr    = (sel + 1) % NI;
      end else begin
        m_locked = 1;
      end
    end
    if (c && sel < 0) begin
      if (m_credits == D) m_err = 1;
      else                m_credits++;
    end else if (!c && sel >= 0) begin
      m_credits--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    req = '0; req_is_tail = '0; credit_in = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("grant", int'(grant), int'(e.grant));
      check("send_out", int'(send_out), int'(|e.grant));
      check("locked", int'(locked), int'(e.locked));
      check("owner", int'(owner), e.owner);
      check("credit_count", int'(credit_count), e.credits);
      check("credit_err", int'(credit_err), int'(e.err));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_grant", int'(grant), 0);
    check("rst_credit", int'(credit_count), D);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(credit_err), 0);

    // Single-flit packets rotate 1, 2, 4, 1 with credits replenished.
    repeat (4) step(5'b10110, 5'b11111, 1'b1);

    // Four-flit packet from input 3 holds the port against input 1.
    repeat (3) step(5'b01010, 5'b00010, 1'b1);
    step(5'b01010, 5'b01010, 1'b1);
    step(5'b00010, 5'b00010, 1'b1);

    // Credit starvation mid-packet from input 0.
    do_reset();
    step(5'b00001, 5'b00000, 1'b0);
    step(5'b00001, 5'b00000, 1'b0);
    step(5'b00001, 5'b00001, 1'b0);
    step(5'b00001, 5'b00001, 1'b1);
    step(5'b00001, 5'b00001, 1'b0);
    step(5'b00000, 5'b00000, 1'b0);
    step(5'b00000, 5'b00000, 1'b1);
    step(5'b00000, 5'b00000, 1'b1);

    // Overflow sets the sticky error; send plus credit leaves count alone.
    step(5'b00000, 5'b00000, 1'b1);
    step(5'b00100, 5'b00100, 1'b0);
    step(5'b00100, 5'b00100, 1'b1);
    step(5'b00000, 5'b00000, 1'b0);

`ifdef OUTPUT_ALLOC_TURN_MASK_EN
    do_reset();
    turn_disable = 5'b00010; m_mask = 5'b00010;
    step(5'b00010, 5'b00010, 1'b0);
    step(5'b00110, 5'b00110, 1'b0);
    step(5'b00000, 5'b00000, 1'b1);
    @(negedge clk);
    #1;
    turn_disable = '0; m_mask = '0;
`endif

    // Asynchronous reset in the middle of a packet from input 3.
    do_reset();
    step(5'b01000, 5'b00000, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    req = 5'b01000; req_is_tail = '0; credit_in = 1'b0;
    #1;
    check("mid_pkt_grant", int'(grant), int'(NI'(1) << model_pick(5'b01000)));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_grant", int'(grant), 0);
    check("rst_async_send", int'(send_out), 0);
    check("rst_async_locked", int'(locked), 0);
    check("rst_async_owner", int'(owner), 0);
    model_reset();
    req = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(5'b01001, 5'b01001, 1'b0);
    step(5'b01000, 5'b01000, 1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [NI-1:0] r, t;
      r = NI'($urandom);
      t = NI'($urandom) | NI'($urandom);
      step(r, t, ($urandom_range(0, 2) == 0));
    end

    @(negedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/output_port_allocator.md
# output_port_allocator

Per-output-port switch allocator for the NoC router. It arbitrates among the router's input ports competing for one output port, using round-robin with wormhole packet locking from head to tail flit. It also tracks downstream credits so no flit is sent without buffer space. One instance sits beside each output port of the router crossbar and drives that port's select and send.

## Interface
Parameters:
- NUM_INPUTS, 5: number of requesting input ports; index 0 is the local injection port.
- FLIT_BUFFER_DEPTH, 2: downstream buffer depth, which is also the initial and maximum credit count.
- CREDIT_W, $clog2(FLIT_BUFFER_DEPTH+1): width of the credit counter.

Ports:
- clk  input  1  NoC clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_INPUTS  input i has a flit at its buffer head routed to this output.
- req_is_tail  input  NUM_INPUTS  the head flit of input i is a tail flit.
- credit_in  input  1  downstream freed one buffer slot (one pulse per slot).
- grant  output  NUM_INPUTS  one-hot crossbar select, combinational; zero or one bit set.
- send_out  output  1  a flit transfers this cycle; equals |grant.
- locked  output  1  a multi-flit packet owns the port.
- owner  output  $clog2(NUM_INPUTS)  index of the owning or last-granted input.
- credit_count  output  CREDIT_W  credits currently available.
- credit_err  output  1  sticky flag: credit_in was received while credit_count == FLIT_BUFFER_DEPTH.

## Operation
- States are IDLE and LOCKED, held in a registered state bit plus an owner register.
- **IDLE**
  - If credit_count > 0 and any eligible req bit is set, grant the first requester at or after the round-robin pointer, searching upward and wrapping from NUM_INPUTS-1 to 0.
  - The flit transfers in the same cycle and owner updates to the granted index.
  - If the granted flit is a tail flit (single-flit packet), stay in IDLE and set pointer = owner+1 (mod NUM_INPUTS).
  - Otherwise go to LOCKED.
- **LOCKED**
  - grant[owner] = req[owner] && credit_count > 0; all other grant bits are 0.
  - A tail transfer returns the block to IDLE and sets pointer = owner+1 (mod NUM_INPUTS).
  - If req[owner] is low (bubble), grant is 0 and the block stays in LOCKED; other inputs are never granted mid-packet.
- **Credits**
  - The counter decrements on send_out and increments on credit_in.
  - When both occur in the same cycle, the counter is unchanged.
  - With credit_count == 0, no grant is issued, even if credit_in arrives that cycle; grant is based on the registered count.
  - credit_in at maximum count saturates the counter and sets credit_err, which stays set until reset.
- **Width rules**
  - Pointer arithmetic wraps modulo NUM_INPUTS, which need not be a power of two.
  - The counter never underflows because a grant requires credit_count > 0.

## Timing
- Grant latency is 0 cycles: grant and send_out are combinational from req, state and the registered credit_count.
- State, owner, pointer, credit_count and credit_err update on the rising clk edge following the transfer.
- Throughput is one flit per cycle while credits are non-zero.
- Reset values:
  - state = IDLE, pointer = 0, owner = 0, locked = 0.
  - credit_count = FLIT_BUFFER_DEPTH, credit_err = 0.
  - grant and send_out are forced to 0 while rst_n is low.
- Reset asserted mid-packet discards the lock immediately and asynchronously. After release, arbitration restarts from pointer 0.

## Configuration
- OUTPUT_ALLOC_TURN_MASK_EN
  - When defined, the block adds the input port turn_disable (NUM_INPUTS bits, static configuration).
  - In IDLE, a req bit is eligible only if its turn_disable bit is 0.
  - Mask changes while LOCKED do not affect the current owner.
- When OUTPUT_ALLOC_TURN_MASK_EN is undefined, the port is absent and every req bit is eligible.

## Structure
- Package router_alloc_pkg holds:
  - the state enum (ALLOC_IDLE, ALLOC_LOCKED);
  - a function for credit width;
  - a function for round-robin next-index modulo.
- Sub-module rr_arbiter: purely combinational round-robin priority arbiter (req, pointer -> one-hot grant, index). The FSM, owner, pointer and credit counter remain in the top module.

## Test plan
- Reset release with req=5'b00000: grant=0, credit_count=2, locked=0, credit_err=0.
- req=5'b10110, all tails, credits kept replenished: grants cycle through inputs 1, 2, 4, 1, one per cycle.
- Input 3 sends a 4-flit packet while input 1 requests throughout, credit_in every cycle: input 3 receives 4 consecutive grants, then input 1 is granted.
- No credit_in, 3-flit packet from input 0: 2 flits are sent, then grant=0 with locked=1. One credit_in pulse produces the third (tail) flit on the next cycle, then locked=0.
- credit_in pulsed at credit_count=2 sets credit_err=1 and credit_count stays 2. send_out and credit_in in the same cycle leave the count unchanged.
- With OUTPUT_ALLOC_TURN_MASK_EN defined, turn_disable=5'b00010 and req=5'b00010: no grant. Reset asserted mid-packet drives grant to 0 immediately, and the owner is lost.
